multiplicacao_num_matriz: RTL and testbench

Scalar-by-matrix multiplier for the matrix co-processor datapath. It multiplies every active element of a square signed 8-bit matrix (2x2 up to 5x5, packed in a 200-bit bus) by a signed 8-bit integer. It returns the packed 8-bit result matrix and a single overflow flag. Outputs are registered with one-cycle latency and a valid strobe.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/mult_elem_s8.sv | 28 ++
 rtl/multiplicacao_num_matriz.sv | 74 +++++++
 tb/tb_multiplicacao_num_matriz.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ------------------------------------------------------------------
// matrix_pkg: shared widths, size encodings and lane-count helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package matrix_pkg;

  localparam int ELEM_W    = 8;
  localparam int MAX_DIM   = 5;
  localparam int NUM_LANES = MAX_DIM * MAX_DIM;
  localparam int BUS_W     = NUM_LANES * ELEM_W;

  typedef enum logic [1:0] {
    SIZE_2X2 = 2'b00,
    SIZE_3X3 = 2'b01,
    SIZE_4X4 = 2'b10,
    SIZE_5X5 = 2'b11
  } size_e;

  // Number of active lanes (N*N) for a matrix_size code.
  function automatic logic [4:0] active_lanes(input logic [1:0] size);
    case (size_e'(size))
      SIZE_2X2: return 5'd4;
      SIZE_3X3: return 5'd9;
      SIZE_4X4: return 5'd16;
      default:  return 5'd25;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_elem_s8.sv
// ------------------------------------------------------------------
// mult_elem_s8: one int8 x int8 lane, wrapped 8-bit result + overflow
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mult_elem_s8 (
  input  logic signed [7:0] elem_i,
  input  logic signed [7:0] scalar_i,
  input  logic              active_i,
  output logic        [7:0] prod_o,
  output logic              ovf_o
);

  logic signed [15:0] w_prod;
  logic               w_fits;

  assign w_prod = elem_i * scalar_i;

  // The product fits int8 only when bits [15:7] are a pure sign extension.
  assign w_fits = (&w_prod[15:7]) | ~(|w_prod[15:7]);

  assign prod_o = active_i ? w_prod[7:0] : 8'd0;
  assign ovf_o  = active_i & ~w_fits;

endmodule

`default_nettype wire

// File: rtl/multiplicacao_num_matriz.sv
// ------------------------------------------------------------------
// multiplicacao_num_matriz: scalar x square int8 matrix, 1-cycle latency
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module multiplicacao_num_matriz #(
  parameter int ELEM_W  = matrix_pkg::ELEM_W,
  parameter int MAX_DIM = matrix_pkg::MAX_DIM
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matriz_A,
  input  logic [ELEM_W-1:0]                   num_inteiro,
  input  logic [1:0]                          matrix_size,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   nova_matriz_A,
  output logic                                overflow_flag,
  output logic                                out_valid
);

  import matrix_pkg::*;

  localparam int LANES = MAX_DIM * MAX_DIM;
  localparam int W_BUS = LANES * ELEM_W;

  logic [4:0]       w_num_active;
  logic [LANES-1:0] w_lane_active;
  logic [LANES-1:0] w_lane_ovf;
  logic [W_BUS-1:0] result_d;
  logic             ovf_d;

  logic [W_BUS-1:0] result_q;
  logic             ovf_q;
  logic             valid_q;

  assign w_num_active = active_lanes(matrix_size);

  // Row-major packing with stride N puts every active element at k < N*N.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lane_active[k] = (5'(k) < w_num_active);

    mult_elem_s8 u_mult (
      .elem_i   (matriz_A[k*ELEM_W +: ELEM_W]),
      .scalar_i (num_inteiro),
      .active_i (w_lane_active[k]),
      .prod_o   (result_d[k*ELEM_W +: ELEM_W]),
      .ovf_o    (w_lane_ovf[k])
    );
  end

  assign ovf_d = |w_lane_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign nova_matriz_A = result_q;
  assign overflow_flag = ovf_q;
  assign out_valid     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplicacao_num_matriz.sv
// ------------------------------------------------------------------
// tb_multiplicacao_num_matriz: directed vectors with hand-computed results
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_multiplicacao_num_matriz;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [199:0] matriz_A;
  logic [7:0]   num_inteiro;
  logic [1:0]   matrix_size;
  logic [199:0] nova_matriz_A;
  logic         overflow_flag;
  logic         out_valid;

  int n_checks;
  int n_fail;
  int a [25];
  int e [25];

  multiplicacao_num_matriz dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .matriz_A      (matriz_A),
    .num_inteiro   (num_inteiro),
    .matrix_size   (matrix_size),
    .nova_matriz_A (nova_matriz_A),
    .overflow_flag (overflow_flag),
    .out_valid     (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] pack(input int v [25]);
    logic [199:0] p;
    p = '0;
    for (int k = 0; k < 25; k++) p[k*8 +: 8] = v[k][7:0];
    return p;
  endfunction

  task automatic clear_vec();
    for (int k = 0; k < 25; k++) begin
      a[k] = 0;
      e[k] = 0;
    end
  endtask

  // Drive one vector (keeps in_valid high), sample #1 after the capture edge.
  task automatic run_vec(input string tag, input logic [1:0] size, input int scalar,
                         input logic exp_ovf);
    @(negedge clk);
    in_valid    = 1'b1;
    matriz_A    = pack(a);
    num_inteiro = scalar[7:0];
    matrix_size = size;
    @(posedge clk);
    #1;
    check({tag, "_res"}, nova_matriz_A, pack(e));
    check({tag, "_ovf"}, 200'(overflow_flag), 200'(exp_ovf));
    check({tag, "_vld"}, 200'(out_valid), 200'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    matriz_A = {25{8'h5A}};
  endtask

  logic [199:0] held;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    matriz_A    = '0;
    num_inteiro = '0;
    matrix_size = '0;
    #1;
    check("rst_res", nova_matriz_A, 200'd0);
    check("rst_ovf", 200'(overflow_flag), 200'd0);
    check("rst_vld", 200'(out_valid), 200'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 2x2, scalar 3
    clear_vec();
    a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4;
    e[0] = 3; e[1] = 6; e[2] = 9; e[3] = 12;
    run_vec("t2x2", 2'b00, 3, 1'b0);

    // 3x3, scalar -2, issued back to back with the previous vector
    clear_vec();
    a[0] = 5;   a[1] = -10; a[2] = 3;  a[3] = -4;  a[4] = 6;
    a[5] = -1;  a[6] = 8;   a[7] = -7; a[8] = 2;
    e[0] = -10; e[1] = 20;  e[2] = -6; e[3] = 8;   e[4] = -12;
    e[5] = 2;   e[6] = -16; e[7] = 14; e[8] = -4;
    a[9] = 99;  a[24] = -99;
    run_vec("t3x3", 2'b01, -2, 1'b0);

    // 4x4, scalar 20: 140 -> -116, -140 -> 116; inactive lanes carry junk
    clear_vec();
    for (int k = 0; k < 16; k++) begin
      a[k] = (k % 2 == 0) ? 7 : -7;
      e[k] = (k % 2 == 0) ? -116 : 116;
    end
    for (int k = 16; k < 25; k++) a[k] = 50;
    run_vec("t4x4", 2'b10, 20, 1'b1);

    // Idle: valid drops, result and flag hold
    held = nova_matriz_A;
    go_idle();
    @(posedge clk);
    #1;
    check("idle_vld", 200'(out_valid), 200'd0);
    check("idle_res", nova_matriz_A, held);
    check("idle_ovf", 200'(overflow_flag), 200'd1);

    // Async reset asserted while a valid vector is presented
    clear_vec();
    for (int k = 0; k < 25; k++) a[k] = k - 12;
    @(negedge clk);
    in_valid    = 1'b1;
    matriz_A    = pack(a);
    num_inteiro = 8'd1;
    matrix_size = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    check("arst_res", nova_matriz_A, 200'd0);
    check("arst_ovf", 200'(overflow_flag), 200'd0);
    check("arst_vld", 200'(out_valid), 200'd0);
    @(posedge clk);
    #1;
    check("arst_edge_vld", 200'(out_valid), 200'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_res", nova_matriz_A, 200'd0);
    check("post_rst_vld", 200'(out_valid), 200'd0);

    // 5x5, scalar 1: pass-through
    clear_vec();
    for (int k = 0; k < 25; k++) begin
      a[k] = k - 12;
      e[k] = k - 12;
    end
    run_vec("t5x5", 2'b11, 1, 1'b0);

    // 2x2, -128 * -1 wraps to -128 and overflows; lane 4 inactive
    clear_vec();
    a[0] = -128; a[4] = 100;
    e[0] = -128;
    run_vec("tmin", 2'b00, -1, 1'b0 | 1'b1);

    // Same with lane 0 = 0, scalar 2: inactive lane 4 (100*2) must not flag
    clear_vec();
    a[4] = 100;
    run_vec("tinact", 2'b00, 2, 1'b0);

    // Scalar 0 on a 5x5 with extreme values
    clear_vec();
    for (int k = 0; k < 25; k++) a[k] = (k % 2 == 0) ? -128 : 127;
    run_vec("tzero", 2'b11, 0, 1'b0);

    // 3x3, scalar 127: 127*127 overflows only on the last active lane
    clear_vec();
    a[8] = 127; e[8] = 1;
    a[0] = 1;   e[0] = 127;
    a[1] = -1;  e[1] = -127;
    run_vec("t127", 2'b01, 127, 1'b1);

    go_idle();
    @(posedge clk);
    #1;
    check("end_vld", 200'(out_valid), 200'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
